jk_bank_using_t: RTL and testbench

Parameterized bank of JK flip-flops whose state is held in toggle (T) cells. Each JK request is converted to a per-bit toggle vector, T = (J & ~Q) | (K & Q), which is then applied. This is the reverse of the T-from-JK conversion already in the flip-flop library. The block sits behind a valid/ready command port so a controller can issue JK updates to the whole bank. It reports the applied toggle vector and a running toggle count for checking.

---
 rtl/jk_bank_using_t.sv | 115 +++++++++++
 tb/tb_jk_bank_using_t.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_using_t.sv
`default_nettype none
// ============================================================================
// Module      : jk_bank_using_t
// Description : Bank of JK flip-flops built from toggle cells. Each accepted
//               JK command is converted to a toggle vector
//               T = (J & ~Q) | (K & Q) and applied on the following falling
//               edge. Reports the applied toggle vector, a done pulse and a
//               saturating count of toggled bits.
// Revision    : 1.0 - initial release
// ============================================================================
module jk_bank_using_t #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] t_vec,
    output logic             done,
    output logic [CNT_W-1:0] toggle_cnt
);

    // Counter arithmetic is carried out five bits wider than the counter so
    // the sum of a full counter and a full-width popcount never wraps.
    localparam int SUM_W = CNT_W + 5;
    localparam logic [SUM_W-1:0] CNT_MAX = {5'b0, {CNT_W{1'b1}}};

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        APPLY = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WIDTH-1:0]  j_r;
    logic [WIDTH-1:0]  k_r;
    logic [WIDTH-1:0]  t_next;
    logic [SUM_W-1:0]  pop_cnt;
    logic [SUM_W-1:0]  sum_wide;
    logic [CNT_W-1:0]  cnt_next;

    // FSM state register; clr forces the bank back to IDLE.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and the ready handshake, which is pure state decode.
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_next = APPLY;
            end
            APPLY: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (clr) state_next = IDLE;
    end

    // Toggle vector from the latched JK pair and the current bank state,
    // plus the saturated counter value it would produce.
    always_comb begin
        t_next  = (j_r & ~q) | (k_r & q);
        pop_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop_cnt = pop_cnt + {{(SUM_W-1){1'b0}}, t_next[i]};
        end
        sum_wide = {5'b0, toggle_cnt} + pop_cnt;
        cnt_next = (sum_wide > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : sum_wide[CNT_W-1:0];
    end

    // Datapath: latch JK on acceptance, apply toggles in APPLY, clear on clr.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            j_r        <= '0;
            k_r        <= '0;
            q          <= '0;
            t_vec      <= '0;
            done       <= 1'b0;
            toggle_cnt <= '0;
        end else if (clr) begin
            q          <= '0;
            t_vec      <= '0;
            done       <= 1'b0;
            toggle_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE && cmd_valid) begin
                j_r <= j;
                k_r <= k;
            end
            if (state == APPLY) begin
                q          <= q ^ t_next;
                t_vec      <= t_next;
                done       <= 1'b1;
                toggle_cnt <= cnt_next;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_using_t.sv
`default_nettype none
// ============================================================================
// Module      : tb_jk_bank_using_t
// Description : Directed self-checking bench for jk_bank_using_t. A second
//               instance with a 4-bit counter shares all stimulus and is used
//               for the saturation case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_bank_using_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       clr;
    logic       cmd_valid;
    logic [3:0] j;
    logic [3:0] k;

    logic       cmd_ready, cmd_ready4;
    logic [3:0] q, q4;
    logic [3:0] t_vec, t_vec4;
    logic       done, done4;
    logic [7:0] toggle_cnt;
    logic [3:0] toggle_cnt4;

    int checks   = 0;
    int failures = 0;
    int pulses;

    jk_bank_using_t #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .clr(clr), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .j(j), .k(k), .q(q), .t_vec(t_vec),
        .done(done), .toggle_cnt(toggle_cnt)
    );

    jk_bank_using_t #(.WIDTH(4), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .clr(clr), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready4), .j(j), .k(k), .q(q4), .t_vec(t_vec4),
        .done(done4), .toggle_cnt(toggle_cnt4)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next active (falling) edge.
    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    // Present one command, then run through its APPLY edge.
    task automatic do_cmd(input logic [3:0] jv, input logic [3:0] kv);
        cmd_valid = 1'b1;
        j = jv;
        k = kv;
        tick();
        cmd_valid = 1'b0;
        tick();
    endtask

    task automatic do_clr;
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        reset = 1'b0; clr = 1'b0; cmd_valid = 1'b0; j = '0; k = '0;
        #12;
        reset = 1'b1;
        check_val("rst_q", q, 4'h0);
        check_val("rst_tvec", t_vec, 4'h0);
        check_val("rst_cnt", toggle_cnt, 8'd0);
        check_val("rst_done", done, 1'b0);
        check_val("rst_ready", cmd_ready, 1'b1);

        // Reset arriving mid-APPLY discards the pending command.
        cmd_valid = 1'b1; j = 4'b1111; k = 4'b0000;
        tick();
        cmd_valid = 1'b0;
        check_val("acc_ready_low", cmd_ready, 1'b0);
        reset = 1'b0;
        #1;
        check_val("async_rst_ready", cmd_ready, 1'b1);
        tick();
        reset = 1'b1;
        check_val("midrst_q", q, 4'h0);
        check_val("midrst_tvec", t_vec, 4'h0);
        check_val("midrst_done", done, 1'b0);
        check_val("midrst_cnt", toggle_cnt, 8'd0);
        tick();
        check_val("midrst_q2", q, 4'h0);
        check_val("midrst_done2", done, 1'b0);
        check_val("midrst_ready", cmd_ready, 1'b1);

        // JK truth table.
        do_cmd(4'b1100, 4'b1010);
        check_val("tt1_tvec", t_vec, 4'b1100);
        check_val("tt1_q", q, 4'b1100);
        check_val("tt1_done", done, 1'b1);
        check_val("tt1_cnt", toggle_cnt, 8'd2);
        tick();
        check_val("tt1_done_drop", done, 1'b0);
        do_cmd(4'b1111, 4'b1111);
        check_val("tt2_tvec", t_vec, 4'b1111);
        check_val("tt2_q", q, 4'b0011);
        check_val("tt2_cnt", toggle_cnt, 8'd6);

        // Back-to-back JK=11 with cmd_valid held high.
        do_clr();
        check_val("clr_q", q, 4'h0);
        check_val("clr_cnt", toggle_cnt, 8'd0);
        cmd_valid = 1'b1; j = 4'b1111; k = 4'b1111;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            check_val($sformatf("b2b_ready%0d", i), cmd_ready, (i % 2 == 0) ? 1'b1 : 1'b0);
            if (done) pulses++;
            if (i == 2) check_val("b2b_q2", q, 4'b1111);
            if (i == 4) check_val("b2b_q4", q, 4'b0000);
            tick();
        end
        cmd_valid = 1'b0;
        if (done) pulses++;
        check_val("b2b_q_final", q, 4'b1111);
        check_val("b2b_pulses", pulses, 3);
        check_val("b2b_cnt", toggle_cnt, 8'd12);

        // Saturation on the 4-bit counter instance.
        do_clr();
        for (int n = 1; n <= 5; n++) begin
            do_cmd(4'b1111, 4'b1111);
            check_val($sformatf("sat_cnt4_%0d", n), toggle_cnt4, (4 * n > 15) ? 15 : 4 * n);
        end
        check_val("sat_cnt8", toggle_cnt, 8'd20);
        tick();
        check_val("sat_hold", toggle_cnt4, 4'd15);

        // clr during APPLY discards the command.
        do_clr();
        cmd_valid = 1'b1; j = 4'b1111; k = 4'b0000;
        tick();
        cmd_valid = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_val("clrapp_q", q, 4'h0);
        check_val("clrapp_done", done, 1'b0);
        check_val("clrapp_ready", cmd_ready, 1'b1);
        tick();
        check_val("clrapp_q2", q, 4'h0);
        check_val("clrapp_done2", done, 1'b0);

        // clr in IDLE blocks a simultaneous command.
        cmd_valid = 1'b1; j = 4'b1111; k = 4'b0000; clr = 1'b1;
        tick();
        clr = 1'b0; cmd_valid = 1'b0;
        check_val("clridle_ready", cmd_ready, 1'b1);
        tick();
        check_val("clridle_q", q, 4'h0);
        check_val("clridle_done", done, 1'b0);

        // Hold with JK=00, then JK changes during APPLY are ignored.
        do_cmd(4'b1010, 4'b0101);
        check_val("hold_setup_q", q, 4'b1010);
        do_cmd(4'b0000, 4'b0000);
        check_val("hold_q", q, 4'b1010);
        check_val("hold_tvec", t_vec, 4'b0000);
        check_val("hold_done", done, 1'b1);
        check_val("hold_cnt", toggle_cnt, 8'd2);
        cmd_valid = 1'b1; j = 4'b0101; k = 4'b1010;
        tick();
        cmd_valid = 1'b0; j = 4'b0000; k = 4'b0000;
        tick();
        check_val("ign_q", q, 4'b0101);
        check_val("ign_tvec", t_vec, 4'b1111);
        check_val("ign_cnt", toggle_cnt, 8'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
